// File: rtl/ptr_packed_qs_v2.sv
// ptr_packed_qs_v2
//   Pointer and occupancy manager for NUM_OF_Q circular queues packed into one
//   shared storage array. Each queue keeps its own read pointer, write pointer
//   and count. Status and pointers for the currently addressed queues are
//   combinational from stored state. The non-empty bitmap and the sticky
//   error flags are registered.
//
// Ports
//   clk, rst_b          clock, asynchronous active-low reset
//   rd_ptr_inc/rd_addr  pop request on queue rd_addr
//   wr_ptr_inc/wr_addr  push request on queue wr_addr
//   flush_en/flush_addr clear queue flush_addr; wins over rd/wr on that queue
//   q_empty             queue rd_addr is empty
//   q_full              queue wr_addr is full
//   q_almost_full       count of queue wr_addr >= AFULL_THRESH
//   rd_ptr_val          read pointer of queue rd_addr (slot read this cycle)
//   wr_ptr_val          write pointer of queue wr_addr (slot written this cycle)
//   rd_q_count          occupancy of queue rd_addr
//   nonempty_vec        registered per-queue non-empty bitmap
//   overflow_err        sticky: push rejected on a full queue
//   underflow_err       sticky: pop rejected on an empty queue
module ptr_packed_qs_v2 #(
  parameter int unsigned BITS_ADDR_PACK   = 4,
  parameter int unsigned NUM_OF_Q         = 2**BITS_ADDR_PACK,
  parameter int unsigned BITS_ADDR_EACH_Q = 2,
  parameter int unsigned DEPTH_EACH_Q     = 2**BITS_ADDR_EACH_Q,
  parameter int unsigned AFULL_THRESH     = DEPTH_EACH_Q-1
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        rd_ptr_inc,
  input  logic                        wr_ptr_inc,
  input  logic [BITS_ADDR_PACK-1:0]   rd_addr,
  input  logic [BITS_ADDR_PACK-1:0]   wr_addr,
  input  logic                        flush_en,
  input  logic [BITS_ADDR_PACK-1:0]   flush_addr,
  output logic                        q_empty,
  output logic                        q_full,
  output logic                        q_almost_full,
  output logic [BITS_ADDR_EACH_Q-1:0] rd_ptr_val,
  output logic [BITS_ADDR_EACH_Q-1:0] wr_ptr_val,
  output logic [BITS_ADDR_EACH_Q:0]   rd_q_count,
  output logic [NUM_OF_Q-1:0]         nonempty_vec,
  output logic                        overflow_err,
  output logic                        underflow_err
);

  localparam int unsigned PW = BITS_ADDR_EACH_Q;
  localparam int unsigned CW = BITS_ADDR_EACH_Q + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_EACH_Q);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  logic [PW-1:0]       rd_ptr_q [NUM_OF_Q];
  logic [PW-1:0]       rd_ptr_d [NUM_OF_Q];
  logic [PW-1:0]       wr_ptr_q [NUM_OF_Q];
  logic [PW-1:0]       wr_ptr_d [NUM_OF_Q];
  logic [CW-1:0]       count_q  [NUM_OF_Q];
  logic [CW-1:0]       count_d  [NUM_OF_Q];
  logic [NUM_OF_Q-1:0] nonempty_q, nonempty_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic flush_rd, flush_wr, same_q, rd_acc, wr_acc;

  always_comb begin
    flush_rd = flush_en && (flush_addr == rd_addr);
    flush_wr = flush_en && (flush_addr == wr_addr);
    same_q   = (rd_addr == wr_addr);
    rd_acc   = rd_ptr_inc && (count_q[rd_addr] != '0) && !flush_rd;
    // A full queue still takes a push when the same queue is popped this cycle.
    wr_acc   = wr_ptr_inc && !flush_wr &&
               ((count_q[wr_addr] != DEPTH_C) || (rd_acc && same_q));

    // Requests dropped by a flush are not errors.
    overflow_d  = overflow_q  || (wr_ptr_inc && !flush_wr && !wr_acc);
    underflow_d = underflow_q || (rd_ptr_inc && !flush_rd && !rd_acc);

    for (int i = 0; i < NUM_OF_Q; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      count_d[i]  = count_q[i];
      if (flush_en && (flush_addr == BITS_ADDR_PACK'(i))) begin
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        count_d[i]  = '0;
      end else begin
        if (rd_acc && (rd_addr == BITS_ADDR_PACK'(i))) begin
          rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
        end
        if (wr_acc && (wr_addr == BITS_ADDR_PACK'(i))) begin
          wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
        end
        count_d[i] = count_q[i]
                   + CW'(wr_acc && (wr_addr == BITS_ADDR_PACK'(i)))
                   - CW'(rd_acc && (rd_addr == BITS_ADDR_PACK'(i)));
      end
      nonempty_d[i] = (count_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NUM_OF_Q; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      nonempty_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OF_Q; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      nonempty_q  <= nonempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign q_empty       = (count_q[rd_addr] == '0);
  assign q_full        = (count_q[wr_addr] == DEPTH_C);
  assign q_almost_full = (count_q[wr_addr] >= AFULL_C);
  assign rd_ptr_val    = rd_ptr_q[rd_addr];
  assign wr_ptr_val    = wr_ptr_q[wr_addr];
  assign rd_q_count    = count_q[rd_addr];
  assign nonempty_vec  = nonempty_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_ptr_packed_qs_v2.sv
module tb_ptr_packed_qs_v2;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       rd_ptr_inc = 1'b0, wr_ptr_inc = 1'b0, flush_en = 1'b0;
  logic [1:0] rd_addr = '0, wr_addr = '0, flush_addr = '0;
  logic       q_empty, q_full, q_almost_full, overflow_err, underflow_err;
  logic [1:0] rd_ptr_val, wr_ptr_val;
  logic [2:0] rd_q_count;
  logic [3:0] nonempty_vec;

  int checks = 0;
  int errors = 0;

  ptr_packed_qs_v2 #(
    .BITS_ADDR_PACK(2), .NUM_OF_Q(4), .BITS_ADDR_EACH_Q(2),
    .DEPTH_EACH_Q(4), .AFULL_THRESH(3)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .rd_ptr_inc(rd_ptr_inc), .wr_ptr_inc(wr_ptr_inc),
    .rd_addr(rd_addr), .wr_addr(wr_addr),
    .flush_en(flush_en), .flush_addr(flush_addr),
    .q_empty(q_empty), .q_full(q_full), .q_almost_full(q_almost_full),
    .rd_ptr_val(rd_ptr_val), .wr_ptr_val(wr_ptr_val), .rd_q_count(rd_q_count),
    .nonempty_vec(nonempty_vec),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference model state
  int m_rd [4];
  int m_wr [4];
  int m_cnt[4];
  bit m_ovf, m_unf;

  typedef struct {
    logic       e, f, af;
    logic [1:0] rp, wp;
    logic [2:0] rc;
    logic [3:0] ne;
    logic       ov, un;
  } exp_t;

  exp_t sb[$];

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_rd[i] = 0; m_wr[i] = 0; m_cnt[i] = 0;
    end
    m_ovf = 0; m_unf = 0;
  endfunction

  function automatic exp_t model_outputs(input logic [1:0] ra, input logic [1:0] wa);
    exp_t x;
    x.e  = (m_cnt[ra] == 0);
    x.f  = (m_cnt[wa] == 4);
    x.af = (m_cnt[wa] >= 3);
    x.rp = 2'(m_rd[ra]);
    x.wp = 2'(m_wr[wa]);
    x.rc = 3'(m_cnt[ra]);
    for (int i = 0; i < 4; i++) x.ne[i] = (m_cnt[i] != 0);
    x.ov = m_ovf;
    x.un = m_unf;
    return x;
  endfunction

  function automatic void model_step(input bit rd, input bit wr, input int ra, input int wa,
                                     input bit fl, input int fa);
    bit frd, fwr, racc, wacc;
    frd  = fl && (fa == ra);
    fwr  = fl && (fa == wa);
    racc = rd && (m_cnt[ra] != 0) && !frd;
    wacc = wr && !fwr && ((m_cnt[wa] < 4) || (racc && ra == wa));
    if (rd && !frd && !racc) m_unf = 1;
    if (wr && !fwr && !wacc) m_ovf = 1;
    if (racc) begin m_rd[ra] = (m_rd[ra] + 1) % 4; m_cnt[ra] = m_cnt[ra] - 1; end
    if (wacc) begin m_wr[wa] = (m_wr[wa] + 1) % 4; m_cnt[wa] = m_cnt[wa] + 1; end
    if (fl) begin m_rd[fa] = 0; m_wr[fa] = 0; m_cnt[fa] = 0; end
  endfunction

  // Scoreboard consumer: compares the cycle's expected view at mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      if ({q_empty, q_full, q_almost_full} !== {x.e, x.f, x.af}) begin
        errors++;
        $display("FAIL sb_status t=%0t got e/f/af=%b%b%b expected %b%b%b",
                 $time, q_empty, q_full, q_almost_full, x.e, x.f, x.af);
      end
      checks++;
      if ({rd_ptr_val, wr_ptr_val, rd_q_count} !== {x.rp, x.wp, x.rc}) begin
        errors++;
        $display("FAIL sb_ptrs t=%0t got rp=%0d wp=%0d cnt=%0d expected rp=%0d wp=%0d cnt=%0d",
                 $time, rd_ptr_val, wr_ptr_val, rd_q_count, x.rp, x.wp, x.rc);
      end
      checks++;
      if ({nonempty_vec, overflow_err, underflow_err} !== {x.ne, x.ov, x.un}) begin
        errors++;
        $display("FAIL sb_regs t=%0t got ne=%b ov=%b un=%b expected ne=%b ov=%b un=%b",
                 $time, nonempty_vec, overflow_err, underflow_err, x.ne, x.ov, x.un);
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit rd, input bit wr, input logic [1:0] ra, input logic [1:0] wa,
                      input bit fl, input logic [1:0] fa);
    rd_ptr_inc = rd; wr_ptr_inc = wr; rd_addr = ra; wr_addr = wa;
    flush_en = fl; flush_addr = fa;
    sb.push_back(model_outputs(ra, wa));
    model_step(rd, wr, int'(ra), int'(wa), fl, int'(fa));
    @(posedge clk);
    #1;
    rd_ptr_inc = 0; wr_ptr_inc = 0; flush_en = 0;
  endtask

  task automatic apply_reset();
    rd_ptr_inc = 0; wr_ptr_inc = 0; flush_en = 0;
    rst_b = 0;
    @(posedge clk);
    #1;
    rst_b = 1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_b = 0;
    rd_addr = 2'd1; wr_addr = 2'd2;
    @(posedge clk);
    #1;
    checks++;
    if ({q_empty, q_full, q_almost_full} !== 3'b100) begin
      errors++;
      $display("FAIL reset_status got %b%b%b expected 100", q_empty, q_full, q_almost_full);
    end
    checks++;
    if ({rd_ptr_val, wr_ptr_val, rd_q_count} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ptrs got rp=%0d wp=%0d cnt=%0d expected 0", rd_ptr_val, wr_ptr_val, rd_q_count);
    end
    checks++;
    if ({nonempty_vec, overflow_err, underflow_err} !== 6'd0) begin
      errors++;
      $display("FAIL reset_regs got ne=%b ov=%b un=%b expected 0", nonempty_vec, overflow_err, underflow_err);
    end
    rst_b = 1;
    model_reset();
  endtask

  task automatic test_fill_overflow();
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 2'd1, 2'd1, 0, 2'd0);
      if (k == 2) begin
        checks++;
        if ({q_almost_full, q_full} !== 2'b10) begin
          errors++;
          $display("FAIL fill_afull got af=%b f=%b expected af=1 f=0", q_almost_full, q_full);
        end
      end
    end
    checks++;
    if ({q_full, wr_ptr_val} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL fill_full got f=%b wp=%0d expected f=1 wp=0", q_full, wr_ptr_val);
    end
    step(0, 1, 2'd1, 2'd1, 0, 2'd0);
    checks++;
    if ({overflow_err, rd_q_count} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL overflow got ov=%b cnt=%0d expected ov=1 cnt=4", overflow_err, rd_q_count);
    end
  endtask

  task automatic test_drain_underflow();
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 2'd1, 2'd1, 0, 2'd0);
    end
    checks++;
    if ({q_empty, nonempty_vec[1]} !== 2'b10) begin
      errors++;
      $display("FAIL drain_empty got e=%b ne1=%b expected e=1 ne1=0", q_empty, nonempty_vec[1]);
    end
    step(1, 0, 2'd1, 2'd1, 0, 2'd0);
    checks++;
    if ({underflow_err, rd_ptr_val} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL underflow got un=%b rp=%0d expected un=1 rp=0", underflow_err, rd_ptr_val);
    end
  endtask

  task automatic test_same_queue();
    apply_reset();
    for (int k = 0; k < 4; k++) step(0, 1, 2'd2, 2'd2, 0, 2'd0);
    step(1, 1, 2'd2, 2'd2, 0, 2'd0);
    checks++;
    if ({rd_ptr_val, wr_ptr_val, rd_q_count, overflow_err} !== {2'd1, 2'd1, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL same_full got rp=%0d wp=%0d cnt=%0d ov=%b expected 1 1 4 0",
               rd_ptr_val, wr_ptr_val, rd_q_count, overflow_err);
    end
    step(1, 1, 2'd3, 2'd3, 0, 2'd0);
    checks++;
    if ({rd_q_count, rd_ptr_val, underflow_err} !== {3'd1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL same_empty got cnt=%0d rp=%0d un=%b expected 1 0 1",
               rd_q_count, rd_ptr_val, underflow_err);
    end
  endtask

  task automatic test_diff_queues();
    apply_reset();
    step(0, 1, 2'd1, 2'd1, 0, 2'd0);
    step(0, 1, 2'd1, 2'd1, 0, 2'd0);
    step(1, 1, 2'd1, 2'd0, 0, 2'd0);
    checks++;
    if ({rd_q_count, rd_ptr_val, wr_ptr_val} !== {3'd1, 2'd1, 2'd1}) begin
      errors++;
      $display("FAIL diff_q1 got cnt=%0d rp=%0d wp0=%0d expected 1 1 1", rd_q_count, rd_ptr_val, wr_ptr_val);
    end
    rd_addr = 2'd0;
    #1;
    checks++;
    if (rd_q_count !== 3'd1) begin
      errors++;
      $display("FAIL diff_q0 got cnt=%0d expected 1", rd_q_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    apply_reset();
    for (int k = 0; k < 3; k++) step(0, 1, 2'd2, 2'd2, 0, 2'd0);
    step(0, 1, 2'd0, 2'd0, 0, 2'd0);
    step(1, 1, 2'd2, 2'd0, 1, 2'd2);
    checks++;
    if ({rd_q_count, rd_ptr_val, overflow_err, underflow_err} !== {3'd0, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL flush_q2 got cnt=%0d rp=%0d ov=%b un=%b expected 0 0 0 0",
               rd_q_count, rd_ptr_val, overflow_err, underflow_err);
    end
    rd_addr = 2'd0; wr_addr = 2'd2;
    #1;
    checks++;
    if ({rd_q_count, wr_ptr_val} !== {3'd2, 2'd0}) begin
      errors++;
      $display("FAIL flush_others got q0cnt=%0d q2wp=%0d expected 2 0", rd_q_count, wr_ptr_val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int q = 0; q < 4; q++) begin
      for (int k = 0; k <= q; k++) step(0, 1, 2'(q), 2'(q), 0, 2'd0);
    end
    step(1, 0, 2'd3, 2'd2, 0, 2'd0);
    rd_addr = 2'd3; wr_addr = 2'd3;
    #2;
    rst_b = 0;
    #1;
    checks++;
    if ({q_empty, q_full, q_almost_full, rd_ptr_val, wr_ptr_val, rd_q_count} !== {3'b100, 7'd0}) begin
      errors++;
      $display("FAIL async_reset_out got e/f/af=%b%b%b rp=%0d wp=%0d cnt=%0d expected 100 0 0 0",
               q_empty, q_full, q_almost_full, rd_ptr_val, wr_ptr_val, rd_q_count);
    end
    checks++;
    if ({nonempty_vec, overflow_err, underflow_err} !== 6'd0) begin
      errors++;
      $display("FAIL async_reset_regs got ne=%b ov=%b un=%b expected 0", nonempty_vec, overflow_err, underflow_err);
    end
    @(posedge clk);
    #1;
    rst_b = 1;
    model_reset();
    step(0, 1, 2'd0, 2'd0, 0, 2'd0);
    checks++;
    if ({wr_ptr_val, rd_q_count} !== {2'd1, 3'd1}) begin
      errors++;
      $display("FAIL post_reset_push got wp=%0d cnt=%0d expected 1 1", wr_ptr_val, rd_q_count);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 120; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_same_queue();
    test_diff_queues();
    test_flush();
    test_async_reset();
    test_random();
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptr_packed_qs_v2.md
# ptr_packed_qs_v2

Parametrised pointer/occupancy manager for a packed bank of NUM_OF_Q independent circular queues sharing one storage array. It supplies per-queue read/write pointers, empty/full/almost-full status and occupancy for the externally addressed queues. Unlike the previous generation, it handles same-queue simultaneous read and write correctly, ignores illegal operations, supports per-queue flush, and exports a registered non-empty bitmap for downstream arbitration. It sits beside the packed queue storage (M20K/MLAB or register array) in the SpMV merge datapath.

## Interface
- BITS_ADDR_PACK, 4: queue-select address width.
- NUM_OF_Q, 2**BITS_ADDR_PACK: number of queues.
- BITS_ADDR_EACH_Q, 2: pointer width per queue; must be ≥1.
- DEPTH_EACH_Q, 2**BITS_ADDR_EACH_Q: entries per queue.
- AFULL_THRESH, DEPTH_EACH_Q-1: occupancy at or above which almost_full asserts; range 1..DEPTH_EACH_Q.
- clk  in  1  clock; all state updates on the rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- rd_ptr_inc  in  1  read request (pop) on queue rd_addr.
- wr_ptr_inc  in  1  write request (push) on queue wr_addr.
- rd_addr  in  BITS_ADDR_PACK  queue addressed for read.
- wr_addr  in  BITS_ADDR_PACK  queue addressed for write.
- flush_en  in  1  flush request for queue flush_addr.
- flush_addr  in  BITS_ADDR_PACK  queue to flush.
- q_empty  out  1  queue rd_addr is empty (combinational).
- q_full  out  1  queue wr_addr is full (combinational).
- q_almost_full  out  1  count of queue wr_addr ≥ AFULL_THRESH (combinational).
- rd_ptr_val  out  BITS_ADDR_EACH_Q  current read pointer of queue rd_addr.
- wr_ptr_val  out  BITS_ADDR_EACH_Q  current write pointer of queue wr_addr.
- rd_q_count  out  BITS_ADDR_EACH_Q+1  occupancy of queue rd_addr.
- nonempty_vec  out  NUM_OF_Q  registered; bit i = queue i count ≠ 0.
- overflow_err  out  1  sticky; push attempted on full queue and rejected.
- underflow_err  out  1  sticky; pop attempted on empty queue and rejected.

## Operation
- Per-queue state: rd_ptr, wr_ptr (BITS_ADDR_EACH_Q bits, wrap mod DEPTH_EACH_Q), count (BITS_ADDR_EACH_Q+1 bits, range 0..DEPTH_EACH_Q).
- Accept rules (evaluated on current-cycle state):
  - rd_acc = rd_ptr_inc & count[rd_addr]≠0 & ~(flush_en & flush_addr==rd_addr).
  - wr_acc = wr_ptr_inc & ~(flush_en & flush_addr==wr_addr) & (count[wr_addr]<DEPTH | (rd_acc & rd_addr==wr_addr)).
- Updates: rd_acc → rd_ptr+1, count−1; wr_acc → wr_ptr+1, count+1. Same queue, both accepted → both pointers advance, count unchanged.
- Different queues, both accepted → each queue updates independently in the same cycle.
- Flush: queue flush_addr gets rd_ptr=wr_ptr=0, count=0; flush beats rd/wr on that queue. Rd/wr dropped this way set no error flags. Operations on other queues proceed.
- Rejected push on full queue (no same-queue pop) → overflow_err set. Rejected pop on empty queue → underflow_err set. Same queue empty with rd+wr → push accepted (count 1), pop rejected, underflow_err set.
- Error flags clear only on reset.
- nonempty_vec[i] <= (next count[i] ≠ 0); it reflects post-update state one cycle later.

## Timing
- Reset (rst_b low, async): all pointers and counts 0, nonempty_vec=0, overflow_err=underflow_err=0. Hence q_empty=1, q_full=0, q_almost_full=0, rd_ptr_val=wr_ptr_val=0, rd_q_count=0.
- Status/pointer outputs: combinational from stored state and current addresses, zero latency. Pointer returned in cycle N is the slot accessed in cycle N; the updated pointer is visible from cycle N+1.
- No bypass: a push in cycle N makes an empty queue non-empty (q_empty=0) from cycle N+1.
- Reset mid-operation discards all in-flight requests; the first accepted operation is the one in the cycle after rst_b deasserts.

## Test plan
BITS_ADDR_PACK=2, BITS_ADDR_EACH_Q=2 (depth 4), AFULL_THRESH=3.
- Fill q1 with 4 pushes → wr_ptr_val 0,1,2,3. After the 3rd push q_almost_full=1; after the 4th q_full=1, wr_ptr_val=0 (wrap). 5th push → ignored, overflow_err=1, count stays 4.
- Pop 4 from q1 → rd_ptr_val 0,1,2,3, then q_empty=1. Extra pop → underflow_err=1, rd_ptr stays 0. nonempty_vec[1] falls one cycle after the last pop.
- Full q2, simultaneous rd+wr on q2 → both pointers +1, count 4, no overflow. Empty q3 rd+wr → count 1, rd_ptr 0, underflow_err=1.
- Push q0 and pop q1 in the same cycle (q1 count 2) → q0 count 1, q1 count 1, both pointers update.
- q2 count 3; flush q2 with a concurrent pop on q2 and push on q0 → q2 ptrs/count 0, no error flag, q0 count +1.
- Assert rst_b low asynchronously mid-stream with q0..q3 partially full → all outputs return to reset values before the next clk edge.
